sobel_frame_scheduler: RTL
==========================

Name: sobel_frame_scheduler

Overview:
- Shares one sobel_filter instance between two pixel sources on whole-frame granularity, with round-robin arbitration between frames.
- Sequences each frame:
  - issues a filter reset pulse, because the filter ends in a terminal done state after each image;
  - streams the granted source's pixels into the filter;
  - counts the filter's output pixels until the frame has drained;
  - tags each output with the owning source ID.
- Sits between the two camera/DMA pixel streams and the filter. The filter has no backpressure, so the scheduler throttles only the input side.

Parameters:
WIDTH_P, 10, image width in pixels (≥3); must match the attached filter.
HEIGHT_P, 10, image height in pixels (≥3); must match the attached filter.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous reset, active-low
src_valid_i  in  2  per-source pixel valid; bit s = source s
src_pixel_i  in  16  source s pixel in bits [8s+7:8s]
src_ready_o  out  2  per-source ready; a pixel transfers when valid & ready
filt_reset_o  out  1  active-high synchronous reset to the filter
filt_valid_o  out  1  pixel valid to the filter
filt_pixel_o  out  8  pixel to the filter
filt_valid_i  in  1  filter output valid
filt_pixel_i  in  8  filter output pixel
out_valid_o  out  1  registered filtered-pixel valid
out_pixel_o  out  8  registered filtered pixel
out_src_o  out  1  source that owns out_pixel_o
out_last_o  out  1  marks the final output pixel of a frame
busy_o  out  1  high in any state except IDLE
frame_done_o  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Let N = WIDTH_P*HEIGHT_P. The in_cnt and out_cnt counters are each $clog2(N+1) bits wide.
- Reset (reset_n_i low at a clock edge):
  - state goes to IDLE; in_cnt = out_cnt = 0; grant_r = 0; last_r = 1, so source 0 wins first.
  - out_valid_o, out_pixel_o, out_src_o, out_last_o and frame_done_o all go to 0.
  - filt_reset_o = 1 while reset_n_i is low.
  - A reset mid-frame abandons that frame; no out_last_o or frame_done_o is produced for it.
- States (one-hot): IDLE, FRST, STREAM, DRAIN, DONE.
- IDLE:
  - A request is src_valid_i[s]=1. src_ready_o = 0.
  - One requester: grant it.
  - Both requesting: grant ~last_r.
  - On a grant: grant_r ← winner, last_r ← winner, go to FRST.
- FRST: lasts exactly one cycle. filt_reset_o = 1, in_cnt = out_cnt = 0, then go to STREAM.
- STREAM:
  - src_ready_o[grant_r] = 1; the other ready bit = 0.
  - filt_valid_o = src_valid_i[grant_r]; filt_pixel_o = the granted pixel. Both are combinational.
  - Each transfer increments in_cnt. The transfer with in_cnt == N-1 moves the state to DRAIN.
  - A source dropping valid mid-frame stalls the stream; the filter tolerates gaps.
- DRAIN:
  - src_ready_o = 0; filt_valid_o = 0.
  - The filter emits its remaining WIDTH_P+1 outputs autonomously.
- Output capture, active in STREAM and DRAIN:
  - Each cycle with filt_valid_i=1: out_valid_o ← 1, out_pixel_o ← filt_pixel_i, out_src_o ← grant_r, out_cnt++. Otherwise out_valid_o ← 0.
  - out_last_o ← (out_cnt == N-1).
  - The capture with out_cnt == N-1 moves the state to DONE. out_last_o is high on the first DONE cycle.
  - filt_valid_i in IDLE, FRST or DONE is ignored, and out_valid_o stays 0.
- DONE: lasts exactly one cycle. frame_done_o = 1, then go to IDLE. The next arbitration happens in IDLE the following cycle.
- Output latency: filter output to out_* is 1 cycle. The filter output is combinational on its input, so input pixel to out_* is 1 cycle while in STREAM.
- Exact output count: the filter produces exactly N outputs per frame, namely (W-1) + W(H-2) + W + 1.
- Minimum frame overhead: IDLE + FRST + DONE = 3 cycles between frames.

Test Plan:
- W=4, H=4; source 0 streams 16 pixels, one per cycle, with values 0..15:
  - exactly 16 out_valid_o pulses, all with out_src_o=0;
  - out_last_o on the 16th pulse, coinciding with frame_done_o;
  - filt_reset_o pulses once, in the cycle before the first transfer.
- Both sources valid from reset, constant pixels 0x10 (source 0) and 0x80 (source 1):
  - frames are granted 0, 1, 0, 1;
  - src_ready_o is never 2'b11;
  - each frame's outputs carry the matching out_src_o;
  - interior pixels are 0 for a flat image.
- Source 0 deasserts valid for 5 cycles after pixel 6:
  - in_cnt holds during the gap;
  - the frame still yields exactly 16 outputs, and no extra filt_valid_o is issued.
- Source 1 alone requests after source 0's frame:
  - source 1 is granted immediately;
  - when source 0 re-requests during that frame, it waits until IDLE.
- reset_n_i is driven low for 1 cycle during DRAIN:
  - all outputs go to 0 and state returns to IDLE;
  - no frame_done_o; filt_reset_o is high during reset;
  - the next frame completes normally, with source 0 granted first.

Source files
------------

// File: rtl/sobel_frame_scheduler.sv
// Frame-granular round-robin arbiter that time-shares one sobel_filter between two
// pixel sources: resets the filter, streams one frame, drains it, and tags the outputs.
module sobel_frame_scheduler #(
    parameter int unsigned WIDTH_P  = 10,
    parameter int unsigned HEIGHT_P = 10
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [1:0]  src_valid_i,
    input  logic [15:0] src_pixel_i,
    output logic [1:0]  src_ready_o,
    output logic        filt_reset_o,
    output logic        filt_valid_o,
    output logic [7:0]  filt_pixel_o,
    input  logic        filt_valid_i,
    input  logic [7:0]  filt_pixel_i,
    output logic        out_valid_o,
    output logic [7:0]  out_pixel_o,
    output logic        out_src_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned N_PIX = WIDTH_P * HEIGHT_P;
    localparam int unsigned CNT_W = $clog2(N_PIX + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        FRST   = 5'b00010,
        STREAM = 5'b00100,
        DRAIN  = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             grant_r;
    logic             last_r;

    logic             winner_c;
    logic             in_xfer_c;
    logic             capture_c;

    // Contention goes to the source that did not own the previous frame.
    assign winner_c  = (&src_valid_i) ? ~last_r : src_valid_i[1];
    assign in_xfer_c = (state == STREAM) && src_valid_i[grant_r];
    assign capture_c = ((state == STREAM) || (state == DRAIN)) && filt_valid_i;

    // Input side is a pure steering path so the filter sees pixels in the transfer cycle.
    assign src_ready_o  = (state == STREAM) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
    assign filt_valid_o = in_xfer_c;
    assign filt_pixel_o = grant_r ? src_pixel_i[15:8] : src_pixel_i[7:0];
    assign filt_reset_o = !reset_n_i || (state == FRST);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            in_cnt       <= '0;
            out_cnt      <= '0;
            grant_r      <= 1'b0;
            last_r       <= 1'b1;
            out_valid_o  <= 1'b0;
            out_pixel_o  <= 8'h00;
            out_src_o    <= 1'b0;
            out_last_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            frame_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (|src_valid_i) begin
                        grant_r <= winner_c;
                        last_r  <= winner_c;
                        state   <= FRST;
                    end
                end
                FRST: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (in_xfer_c) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                        if (in_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= DRAIN;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The final filter output of the frame ends it, overriding any stream transition.
            if (capture_c) begin
                out_valid_o <= 1'b1;
                out_pixel_o <= filt_pixel_i;
                out_src_o   <= grant_r;
                out_cnt     <= out_cnt + CNT_W'(1);
                out_last_o  <= (out_cnt == LAST_IDX);
                if (out_cnt == LAST_IDX) begin
                    state        <= DONE;
                    frame_done_o <= 1'b1;
                end
            end
        end
    end

endmodule
